fb_write_arbiter: RTL and testbench
===================================

// Module: fb_write_arbiter
// PURPOSE
//  Owns the single write port of the 320x240 RGB565 frame buffer. Shares it between two
//  pixel requesters (valid/ready, x/y coordinates) with round-robin arbitration. Also runs a
//  full-screen clear/fill engine that starts only during vertical blanking. Converts (x,y) to a
//  linear address; the VGA read side of the frame buffer is untouched.
// PARAMETERS
//  WIDTH   320  pixels per line
//  HEIGHT  240  lines per frame
//  ADDR_W  17   frame buffer address width (must hold WIDTH*HEIGHT-1)
//  PIX_W   16   pixel width (RGB565)
// PORTS
//  clk          in   1       system clock; single clock domain
//  reset        in   1       synchronous, active-high reset
//  vblank       in   1       high while VGA is in vertical blanking
//  clear_start  in   1       1-cycle pulse: request a full-screen fill
//  clear_color  in   PIX_W   fill colour, sampled with clear_start
//  clear_busy   out  1       high from the cycle after clear_start accepted until the fill ends
//  req0_valid   in   1       requester 0 has a pixel
//  req0_ready   out  1       requester 0 pixel accepted this cycle (valid&ready)
//  req0_x       in   9       column
//  req0_y       in   8       row
//  req0_pixel   in   PIX_W   colour
//  req1_*       (same as req0_*, requester 1)
//  fb_we        out  1       frame buffer write enable (registered)
//  fb_addr      out  ADDR_W  frame buffer write address (registered)
//  fb_pixel     out  PIX_W   frame buffer write data (registered)
//  drop_count   out  16      count of accepted out-of-range pixels; saturates at 0xFFFF
// BEHAVIOUR
//  Reset: state=IDLE, fb_we=0, fb_addr=0, fb_pixel=0, clear_busy=0, drop_count=0,
//   readies=0, last_grant=1 (req0 wins first tie).
//  States: IDLE (arbitrating), CLR_WAIT, CLR_RUN.
//  IDLE: clear_start=1 -> CLR_WAIT next cycle, latch clear_color. In that same cycle both
//   readies are 0 (clear wins).
//   Otherwise, if exactly one valid, grant it. If both valid, grant the requester that is
//   not last_grant; update last_grant on every grant.
//   readyN is combinational from valids/state/last_grant. Max one grant per cycle.
//  Accept in cycle N -> fb_we=1, fb_addr=y*WIDTH+x, fb_pixel=pixel in cycle N+1.
//   Latency is 1 cycle. Throughput is 1 pixel/cycle.
//  Out of range (x>=WIDTH or y>=HEIGHT): pixel still accepted (ready=1). fb_we=0 at N+1;
//   drop_count++.
//  No grant in a cycle -> fb_we=0 next cycle; fb_addr/fb_pixel hold their last values.
//  CLR_WAIT: readies=0, fb_we=0. When vblank=1 -> CLR_RUN next cycle, counter=0.
//  CLR_RUN: readies=0. Each cycle fb_we=1, fb_addr=counter, fb_pixel=latched colour;
//   counter++. After the write of WIDTH*HEIGHT-1 (76799) -> IDLE.
//   Exactly WIDTH*HEIGHT writes; the fill does not stop if vblank drops.
//  clear_busy=1 in CLR_WAIT and CLR_RUN; it falls in the first IDLE cycle.
//   clear_start while busy is ignored.
//  Mid-operation reset returns to the reset state next cycle. The fill is abandoned and
//   fb_we=0.
//  Address math: y*WIDTH+x in ADDR_W bits; never exceeds WIDTH*HEIGHT-1 for in-range input.
// TESTING
//  Single: req0 (x=5,y=2,pix=0xF800) for 1 cycle -> next cycle fb_we=1, fb_addr=645,
//   fb_pixel=0xF800.
//  Contention: both valid for 4 cycles after reset -> grants 0,1,0,1; fb_addr stream
//   alternates accordingly.
//  Range: req1 x=320,y=0 -> req1_ready=1, fb_we stays 0, drop_count=1. y=240 -> drop_count=2.
//  Clear: clear_start (color 0x001F), vblank low 10 cycles then high -> no writes for 10
//   cycles, then 76800 consecutive writes at addr 0..76799 with 0x001F. Readies held 0.
//   clear_busy falls after the last write.
//  Collision: clear_start with req0_valid in same cycle -> req0_ready=0. req0 is served only
//   after the clear ends.
//  Reset at fill addr 1000 -> fb_we=0 next cycle, clear_busy=0, IDLE. A new request is
//   granted to req0.

Source files
------------

// File: rtl/fb_write_arbiter.sv
// Frame buffer write-port owner for a 320x240 RGB565 display.
// Two pixel requesters share the single write port through round-robin
// arbitration. A full-screen fill engine takes the port exclusively and
// starts only during vertical blanking. All frame buffer outputs are registered.
`timescale 1ns/1ps

module fb_write_arbiter #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240,
    parameter int ADDR_W = 17,
    parameter int PIX_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vblank,

    input  logic              clear_start,
    input  logic [PIX_W-1:0]  clear_color,
    output logic              clear_busy,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [8:0]        req0_x,
    input  logic [7:0]        req0_y,
    input  logic [PIX_W-1:0]  req0_pixel,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [8:0]        req1_x,
    input  logic [7:0]        req1_y,
    input  logic [PIX_W-1:0]  req1_pixel,

    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [PIX_W-1:0]  fb_pixel,
    output logic [15:0]       drop_count
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_WAIT = 2'd1,
        CLR_RUN  = 2'd2
    } state_t;

    // Address of the final pixel; the fill stops after writing it.
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [15:0]       DROP_MAX  = 16'hFFFF;

    state_t             state;
    logic               last_grant;   // 0: req0 won last, 1: req1 won last
    logic [PIX_W-1:0]   fill_color;

    logic               arb_open;
    logic               grant0;
    logic               grant1;
    logic               grant_any;
    logic [8:0]         sel_x;
    logic [7:0]         sel_y;
    logic [PIX_W-1:0]   sel_pixel;
    logic               in_range;
    logic [ADDR_W-1:0]  lin_addr;

    // Requesters are only served in IDLE; a clear request in the same cycle
    // takes priority, and nothing is accepted while reset is held.
    assign arb_open = (state == IDLE) && !clear_start && !reset;

    // Round-robin: on a tie the requester that did not win last time is served.
    assign grant0    = arb_open && req0_valid && (!req1_valid ||  last_grant);
    assign grant1    = arb_open && req1_valid && (!req0_valid || !last_grant);
    assign grant_any = grant0 || grant1;

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Route the winning requester's coordinates and colour to the write path.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        sel_x     = req0_x;
        sel_y     = req0_y;
        sel_pixel = req0_pixel;
        if (grant1) begin
            sel_x     = req1_x;
            sel_y     = req1_y;
            sel_pixel = req1_pixel;
        end
    end

    // Coordinates outside the screen are accepted but turned into drops.
    assign in_range = (32'(sel_x) < WIDTH) && (32'(sel_y) < HEIGHT);

    // Row-major linear address; bounded by LAST_ADDR for in-range input.
    assign lin_addr = ADDR_W'(sel_y) * ADDR_W'(WIDTH) + ADDR_W'(sel_x);

    // Control FSM plus all registered frame buffer outputs and the drop counter.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            fill_color <= '0;
            clear_busy <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_pixel   <= '0;
            drop_count <= '0;
        end else begin
            // Write enable is a single-cycle strobe; address and data hold.
            fb_we <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (clear_start) begin
                        state      <= CLR_WAIT;
                        fill_color <= clear_color;
                        clear_busy <= 1'b1;
                    end else if (grant_any) begin
                        last_grant <= grant1;
                        if (in_range) begin
                            fb_we    <= 1'b1;
                            fb_addr  <= lin_addr;
                            fb_pixel <= sel_pixel;
                        end else if (drop_count != DROP_MAX) begin
                            drop_count <= drop_count + 16'd1;
                        end
                    end
                end

                CLR_WAIT: begin
                    // Wait for blanking so the fill does not tear a visible frame.
                    if (vblank) begin
                        state    <= CLR_RUN;
                        fb_we    <= 1'b1;
                        fb_addr  <= '0;
                        fb_pixel <= fill_color;
                    end
                end

                CLR_RUN: begin
                    // fb_addr doubles as the fill counter; vblank no longer matters.
                    if (fb_addr == LAST_ADDR) begin
                        state      <= IDLE;
                        clear_busy <= 1'b0;
                    end else begin
                        fb_we   <= 1'b1;
                        fb_addr <= fb_addr + ADDR_W'(1);
                    end
                end

                default: begin
                    state      <= IDLE;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed stimulus pushes expected
// frame buffer writes into a queue; a negedge monitor pops and compares them
// whenever fb_we is seen, and flags any write nobody expected.
`timescale 1ns/1ps

module tb_fb_write_arbiter;

    typedef struct packed {
        logic [16:0] addr;
        logic [15:0] pixel;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vblank = 1'b0;
    logic        clear_start = 1'b0;
    logic [15:0] clear_color = '0;
    logic        clear_busy;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [8:0]  req0_x = '0;
    logic [7:0]  req0_y = '0;
    logic [15:0] req0_pixel = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [8:0]  req1_x = '0;
    logic [7:0]  req1_y = '0;
    logic [15:0] req1_pixel = '0;
    logic        fb_we;
    logic [16:0] fb_addr;
    logic [15:0] fb_pixel;
    logic [15:0] drop_count;

    wr_t exp_q[$];
    wr_t mon_item;
    int  errors = 0;
    int  checks = 0;
    bit  mon_en = 1'b0;

    fb_write_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .vblank      (vblank),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .clear_busy  (clear_busy),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_x      (req0_x),
        .req0_y      (req0_y),
        .req0_pixel  (req0_pixel),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_x      (req1_x),
        .req1_y      (req1_y),
        .req1_pixel  (req1_pixel),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_pixel    (fb_pixel),
        .drop_count  (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [8:0] x, input logic [7:0] y, input logic [15:0] p);
        req0_valid = v; req0_x = x; req0_y = y; req0_pixel = p;
    endtask

    task automatic drive1(input logic v, input logic [8:0] x, input logic [7:0] y, input logic [15:0] p);
        req1_valid = v; req1_x = x; req1_y = y; req1_pixel = p;
    endtask

    task automatic expect_wr(input logic [16:0] a, input logic [15:0] p);
        wr_t w;
        w.addr  = a;
        w.pixel = p;
        exp_q.push_back(w);
    endtask

    // Monitor: every write the DUT presents must match the head of the queue.
    always @(negedge clk) begin
        if (mon_en && fb_we !== 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h pixel 0x%0h, expected no write (t=%0t)",
                         fb_addr, fb_pixel, $time);
            end else begin
                mon_item = exp_q.pop_front();
                check("wr_we",    32'(fb_we),    32'd1);
                check("wr_addr",  32'(fb_addr),  32'(mon_item.addr));
                check("wr_pixel", 32'(fb_pixel), 32'(mon_item.pixel));
            end
        end
    end

    // Expected grant pattern for the 4-cycle contention test: 0,1,0,1.
    logic [3:0] cont_g0;
    logic [3:0] cont_g1;

    initial begin
        cont_g0 = 4'b0101;
        cont_g1 = 4'b1010;

        // ---------------- reset state ----------------
        reset = 1'b1;
        drive0(1'b1, 9'd3, 8'd3, 16'h5555);
        step();
        step();
        @(negedge clk);
        check("rst_fb_we",      32'(fb_we),      32'd0);
        check("rst_fb_addr",    32'(fb_addr),    32'd0);
        check("rst_fb_pixel",   32'(fb_pixel),   32'd0);
        check("rst_clear_busy", 32'(clear_busy), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_req0_ready", 32'(req0_ready), 32'd0);
        check("rst_req1_ready", 32'(req1_ready), 32'd0);
        step();
        reset = 1'b0;
        drive0(1'b0, 9'd0, 8'd0, 16'h0);
        mon_en = 1'b1;

        // ---------------- contention: grants 0,1,0,1 ----------------
        drive0(1'b1, 9'd10, 8'd0, 16'hAAAA);   // addr 10
        drive1(1'b1, 9'd20, 8'd1, 16'hBBBB);   // addr 1*320+20 = 340
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("cont_req0_ready", 32'(req0_ready), 32'(cont_g0[i]));
            check("cont_req1_ready", 32'(req1_ready), 32'(cont_g1[i]));
            if (cont_g0[i]) expect_wr(17'd10,  16'hAAAA);
            else            expect_wr(17'd340, 16'hBBBB);
            step();
        end
        drive0(1'b0, 9'd0, 8'd0, 16'h0);
        drive1(1'b0, 9'd0, 8'd0, 16'h0);
        step();

        // ---------------- single pixel ----------------
        drive0(1'b1, 9'd5, 8'd2, 16'hF800);    // 2*320+5 = 645
        @(negedge clk);
        check("single_req0_ready", 32'(req0_ready), 32'd1);
        expect_wr(17'd645, 16'hF800);
        step();
        drive0(1'b0, 9'd0, 8'd0, 16'h0);
        step();
        step();

        // ---------------- out of range ----------------
        drive1(1'b1, 9'd320, 8'd0, 16'h1111);
        @(negedge clk);
        check("range_x_ready", 32'(req1_ready), 32'd1);
        step();
        drive1(1'b0, 9'd0, 8'd0, 16'h0);
        @(negedge clk);
        check("range_x_drop", 32'(drop_count), 32'd1);
        step();
        drive1(1'b1, 9'd0, 8'd240, 16'h2222);
        @(negedge clk);
        check("range_y_ready", 32'(req1_ready), 32'd1);
        step();
        drive1(1'b0, 9'd0, 8'd0, 16'h0);
        @(negedge clk);
        check("range_y_drop", 32'(drop_count), 32'd2);
        step();

        // Last in-range pixel: 239*320+319 = 76799.
        drive1(1'b1, 9'd319, 8'd239, 16'h07E0);
        @(negedge clk);
        check("corner_ready", 32'(req1_ready), 32'd1);
        expect_wr(17'd76799, 16'h07E0);
        step();
        drive1(1'b0, 9'd0, 8'd0, 16'h0);
        @(negedge clk);
        check("corner_drop", 32'(drop_count), 32'd2);
        step();
        @(negedge clk);
        check("hold_we",    32'(fb_we),    32'd0);
        check("hold_addr",  32'(fb_addr),  32'd76799);
        check("hold_pixel", 32'(fb_pixel), 32'h07E0);
        step();

        // ---------------- clear with collision ----------------
        drive0(1'b1, 9'd1, 8'd1, 16'h1234);    // 1*320+1 = 321
        clear_start = 1'b1;
        clear_color = 16'h001F;
        vblank      = 1'b0;
        @(negedge clk);
        check("collide_req0_ready", 32'(req0_ready), 32'd0);
        check("collide_busy_pre",   32'(clear_busy), 32'd0);
        step();
        clear_start = 1'b0;
        clear_color = 16'hDEAD;                // must not affect the latched colour
        @(negedge clk);
        check("clr_busy_wait", 32'(clear_busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("clr_wait_ready", 32'(req0_ready), 32'd0);
            step();
        end
        for (int k = 0; k < 76800; k++) expect_wr(17'(k), 16'h001F);
        expect_wr(17'd321, 16'h1234);
        vblank = 1'b1;
        for (int k = 0; k < 76800; k++) begin
            step();
            if (k == 5) vblank = 1'b0;         // fill must continue without vblank
            @(negedge clk);
            check("clr_run_ready", 32'(req0_ready), 32'd0);
        end
        check("clr_busy_last", 32'(clear_busy), 32'd1);
        step();
        @(negedge clk);
        check("clr_busy_end",    32'(clear_busy), 32'd0);
        check("post_clr_ready0", 32'(req0_ready), 32'd1);
        step();
        drive0(1'b0, 9'd0, 8'd0, 16'h0);
        @(negedge clk);
        check("post_clr_drop", 32'(drop_count), 32'd2);
        step();

        // ---------------- reset during fill ----------------
        clear_start = 1'b1;
        clear_color = 16'hFFFF;
        step();
        clear_start = 1'b0;
        step();
        step();
        for (int k = 0; k <= 1000; k++) expect_wr(17'(k), 16'hFFFF);
        vblank = 1'b1;
        for (int k = 0; k <= 1000; k++) step();   // fill presenting address 1000
        reset  = 1'b1;
        vblank = 1'b0;
        @(negedge clk);
        check("midrst_addr_before", 32'(fb_addr), 32'd1000);
        step();
        @(negedge clk);
        check("midrst_we",    32'(fb_we),      32'd0);
        check("midrst_busy",  32'(clear_busy), 32'd0);
        check("midrst_addr",  32'(fb_addr),    32'd0);
        check("midrst_drop",  32'(drop_count), 32'd0);
        step();
        reset = 1'b0;
        drive0(1'b1, 9'd2, 8'd0, 16'h3333);
        drive1(1'b1, 9'd3, 8'd0, 16'h4444);
        @(negedge clk);
        check("midrst_req0_ready", 32'(req0_ready), 32'd1);
        check("midrst_req1_ready", 32'(req1_ready), 32'd0);
        expect_wr(17'd2, 16'h3333);
        step();
        drive0(1'b0, 9'd0, 8'd0, 16'h0);
        drive1(1'b0, 9'd0, 8'd0, 16'h0);
        repeat (4) step();
        @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
